// File: rtl/display_pkg.sv
// Shared widths, index and state types for the AES block display sequencer.
package display_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned NUM_WORDS = DATA_W / WORD_W;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  // Big-endian bit order: bit 0 is the MSB of word 0.
  typedef logic [0:WORD_W-1] word_t;
  typedef logic [0:DATA_W-1] block_t;
  typedef logic [IDX_W-1:0]  word_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  localparam word_idx_t LAST_IDX = word_idx_t'(NUM_WORDS - 1);

endpackage

// File: rtl/display_sequencer_dwell_timer.sv
// Auto-advance dwell timer. Reloads while clear is high and counts down on
// each enabled cycle; expire fires on the DWELL_CYCLES-th enabled cycle
// after the last clear.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned    CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter: reload on clear, decrement while enabled, hold at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= LOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = enable & ~clear & (cnt_q == '0);

endmodule

// File: rtl/display_sequencer.sv
// Steps a captured 128-bit AES block onto the 16-bit display path one word
// at a time. Optional auto-cycle is built with DISPLAY_AUTOCYCLE_EN defined;
// otherwise words advance only on i_next and DWELL_CYCLES is ignored.
// Word/block widths come from display_pkg.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no block held; waiting for a block offer
//   SHOW  | one cycle: refresh pulse, current word driven to the latch
//   HOLD  | word held on the latch; waiting for advance or a new block
module display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  block_t    i_block,
  input  logic      i_block_valid,
  output logic      o_block_ready,
  input  logic      i_next,
  output word_t     o_data,
  output logic      o_refresh_display,
  output word_idx_t o_word_idx,
  output logic      o_busy
);

  seq_state_t state_q, state_d;
  block_t     buf_q;
  word_idx_t  idx_q, idx_d;
  logic       load;
  logic       accept;
  logic       advance;
  logic       dwell_expire;
  word_t      cur_word;

  assign o_block_ready = ~rst & (state_q != SHOW);
  assign accept        = i_block_valid & o_block_ready;

`ifdef DISPLAY_AUTOCYCLE_EN
  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != HOLD),
    .enable (state_q == HOLD),
    .expire (dwell_expire)
  );
`else
  logic unused_dwell;
  assign unused_dwell = ^DWELL_CYCLES;
  assign dwell_expire = 1'b0;
`endif

  assign advance = (state_q == HOLD) & (i_next | dwell_expire);

  // State, index and captured block registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) buf_q <= i_block;
    end
  end

  // Next state: a new block beats an advance in HOLD; SHOW always lasts one cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (accept) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SHOW;
        end else if (advance) begin
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          state_d = SHOW;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Word select from the buffer; outputs forced to zero while in reset.
  always_comb begin
    cur_word          = buf_q[int'(idx_q) * WORD_W +: WORD_W];
    o_data            = rst ? '0 : cur_word;
    o_word_idx        = rst ? '0 : idx_q;
    o_refresh_display = ~rst & (state_q == SHOW);
    o_busy            = ~rst & (state_q != IDLE);
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: reset, stepping, wrap, collision,
// ignored inputs, mid-block reset, and (with DISPLAY_AUTOCYCLE_EN) auto-cycle.
module tb_display_sequencer;
  import display_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  block_t    i_block;
  logic      i_block_valid;
  logic      o_block_ready;
  logic      i_next;
  word_t     o_data;
  logic      o_refresh_display;
  word_idx_t o_word_idx;
  logic      o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  localparam block_t BLK_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam block_t BLK_B = 128'hFFFF_1111_2222_3333_4444_5555_6666_7777;
  localparam block_t BLK_C = 128'hC0DE_0001_0002_0003_0004_0005_0006_0007;

  logic [15:0] words_a [0:7] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

  display_sequencer #(
    .DWELL_CYCLES (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_block           (i_block),
    .i_block_valid     (i_block_valid),
    .o_block_ready     (o_block_ready),
    .i_next            (i_next),
    .o_data            (o_data),
    .o_refresh_display (o_refresh_display),
    .o_word_idx        (o_word_idx),
    .o_busy            (o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic rf,
                         input logic [2:0] ix, input logic bz);
    chk({tag, " data"},    32'(o_data), 32'(d));
    chk({tag, " refresh"}, 32'(o_refresh_display), 32'(rf));
    chk({tag, " idx"},     32'(o_word_idx), 32'(ix));
    chk({tag, " busy"},    32'(o_busy), 32'(bz));
  endtask

  task automatic pulse_next();
    i_next = 1'b1;
    step();
    i_next = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_block = '0; i_block_valid = 1'b0; i_next = 1'b0;

    // reset
    step(); step();
    chk_out("reset", 16'h0000, 1'b0, 3'd0, 1'b0);
    chk("reset ready", 32'(o_block_ready), 32'd0);
    rst = 1'b0; #1;
    chk("post-reset ready", 32'(o_block_ready), 32'd1);
    chk("post-reset busy", 32'(o_busy), 32'd0);

    // i_next in IDLE ignored
    pulse_next(); #0;
    chk_out("next in idle", 16'h0000, 1'b0, 3'd0, 1'b0);

    // load block A
    i_block = BLK_A; i_block_valid = 1'b1;
    step();
    i_block_valid = 1'b0;
    chk_out("load A", 16'h0011, 1'b1, 3'd0, 1'b1);
    chk("show ready", 32'(o_block_ready), 32'd0);
    step();
    chk_out("hold A0", 16'h0011, 1'b0, 3'd0, 1'b1);
    chk("hold ready", 32'(o_block_ready), 32'd1);
    step(); step();

    // step through words 1..7, four cycles apart
    for (int w = 1; w < 8; w++) begin
      pulse_next();
      chk_out($sformatf("step w%0d", w), words_a[w], 1'b1, 3'(w), 1'b1);
      step();
      chk_out($sformatf("hold w%0d", w), words_a[w], 1'b0, 3'(w), 1'b1);
      step(); step();
    end

    // wrap 7 -> 0
    pulse_next();
    chk_out("wrap", 16'h0011, 1'b1, 3'd0, 1'b1);
    step();
    chk_out("wrap hold", 16'h0011, 1'b0, 3'd0, 1'b1);

    // go to idx 3
    for (int k = 0; k < 3; k++) begin
      pulse_next();
      step();
    end
    chk_out("at idx3", 16'h6677, 1'b0, 3'd3, 1'b1);

    // collision: new block beats advance
    i_next = 1'b1; i_block = BLK_B; i_block_valid = 1'b1;
    step();
    i_next = 1'b0; i_block_valid = 1'b0;
    chk_out("collision", 16'hFFFF, 1'b1, 3'd0, 1'b1);
    step();
    chk_out("collision hold", 16'hFFFF, 1'b0, 3'd0, 1'b1);

    // i_next during SHOW ignored
    pulse_next();
    chk_out("B step1", 16'h1111, 1'b1, 3'd1, 1'b1);
    pulse_next();
    chk_out("next in show", 16'h1111, 1'b0, 3'd1, 1'b1);
    step();
    chk_out("next in show after", 16'h1111, 1'b0, 3'd1, 1'b1);

    // valid during SHOW held off one cycle
    pulse_next();
    chk_out("B step2", 16'h2222, 1'b1, 3'd2, 1'b1);
    i_block = BLK_C; i_block_valid = 1'b1;
    #1;
    chk("ready in show", 32'(o_block_ready), 32'd0);
    step();
    chk_out("held off", 16'h2222, 1'b0, 3'd2, 1'b1);
    chk("ready after show", 32'(o_block_ready), 32'd1);
    step();
    i_block_valid = 1'b0;
    chk_out("accept C", 16'hC0DE, 1'b1, 3'd0, 1'b1);
    step();
    pulse_next();
    chk_out("C step1", 16'h0001, 1'b1, 3'd1, 1'b1);
    step();

    // reset mid-HOLD
    rst = 1'b1; #1;
    chk_out("rst mid-hold", 16'h0000, 1'b0, 3'd0, 1'b0);
    chk("rst mid-hold ready", 32'(o_block_ready), 32'd0);
    step();
    rst = 1'b0; #1;
    chk_out("after mid rst", 16'h0000, 1'b0, 3'd0, 1'b0);
    chk("after mid rst ready", 32'(o_block_ready), 32'd1);

`ifdef DISPLAY_AUTOCYCLE_EN
    // auto-cycle with DWELL_CYCLES=4: refresh every 5 cycles, wraps after idx 7
    i_block = BLK_A; i_block_valid = 1'b1;
    step();
    i_block_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_out($sformatf("auto show %0d", k), words_a[k % 8], 1'b1, 3'(k % 8), 1'b1);
      for (int j = 0; j < 4; j++) begin
        step();
        chk($sformatf("auto gap %0d.%0d", k, j), 32'(o_refresh_display), 32'd0);
      end
      step();
    end
    step(); step();
    rst = 1'b1; #1;
    chk_out("auto rst", 16'h0000, 1'b0, 3'd0, 1'b0);
    step();
    rst = 1'b0; #1;
    chk_out("auto after rst", 16'h0000, 1'b0, 3'd0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
